// File: rtl/plab5_mcore_net_msg_to_mem_resp_msg_if.sv
// Handshake bundles for the net-to-memory-response adapter.
//   plab5_net_msg_if  : network side. val/domain/msg_control/msg_data flow
//                       master->slave, rdy flows back.
//   plab5_mem_resp_if : memory-response side. Same shape plus src, which
//                       carries the originating bank id of the response.

interface plab5_net_msg_if #(
  parameter int p_cnbits = 23,
  parameter int p_dnbits = 32
);
  logic                val;
  logic                rdy;
  logic                domain;
  logic [p_cnbits-1:0] msg_control;
  logic [p_dnbits-1:0] msg_data;

  modport master (output val, domain, msg_control, msg_data, input  rdy);
  modport slave  (input  val, domain, msg_control, msg_data, output rdy);
endinterface

interface plab5_mem_resp_if #(
  parameter int p_cnbits = 13,
  parameter int p_dnbits = 32,
  parameter int p_snbits = 3
);
  logic                val;
  logic                rdy;
  logic                domain;
  logic [p_cnbits-1:0] msg_control;
  logic [p_dnbits-1:0] msg_data;
  logic [p_snbits-1:0] src;

  modport master (output val, domain, msg_control, msg_data, src, input  rdy);
  modport slave  (input  val, domain, msg_control, msg_data, src, output rdy);
endinterface

// File: rtl/plab5_mcore_net_msg_to_mem_resp_msg.sv
// Core-side receiver for memory responses coming off the response network.
// Strips {dest, src, net opaque} from the net control half, keeps the memory
// response control {type, opaque, len} and data, and buffers the result in a
// 2-entry queue. Each entry carries its own security domain and source bank.
// Messages addressed to another core, or claiming a non-existent source, are
// accepted but discarded and counted.
//
// Ports
//   clk, reset  : clock, synchronous active-high reset
//   net_msg     : slave side of the incoming net message (val/rdy/domain/
//                 msg_control/msg_data)
//   mem_resp    : master side of the outgoing memory response (val/rdy/
//                 domain/msg_control/msg_data/src), driven from the head entry
//   drop_count  : saturating (255) count of discarded messages
//   drop_err    : sticky, set by the first discard since reset

module plab5_mcore_net_msg_to_mem_resp_msg #(
  parameter int p_net_dest          = 0,
  parameter int p_num_ports         = 4,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 3
)(
  input  logic                    clk,
  input  logic                    reset,
  plab5_net_msg_if.slave          net_msg,
  plab5_mem_resp_if.master        mem_resp,
  output logic [7:0]              drop_count,
  output logic                    drop_err
);

  // Memory response control = {type(3), opaque(mo), len(log2(md/8))}.
  localparam int md               = p_mem_data_nbits;
  localparam int ns               = p_net_srcdest_nbits;
  localparam int c_mem_msg_cnbits = 3 + p_mem_opaque_nbits + $clog2(md/8);
  localparam int c_net_msg_cnbits = c_mem_msg_cnbits + p_net_opaque_nbits + 2*ns;

  typedef struct packed {
    logic                        domain;
    logic [ns-1:0]               src;
    logic [c_mem_msg_cnbits-1:0] ctrl;
    logic [md-1:0]               data;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_next;
  entry_t entries [2];
  logic   wr_ptr, rd_ptr;

  // ---------------------------------------------------------------------
  // Header decode
  // ---------------------------------------------------------------------
  logic [ns-1:0]               msg_dest;
  logic [ns-1:0]               msg_src;
  logic [c_mem_msg_cnbits-1:0] msg_mem_ctrl;
  logic                        misrouted;

  // The net opaque field sits between src and the memory control and is
  // deliberately not extracted.
  assign msg_dest     = net_msg.msg_control[c_net_msg_cnbits-1    -: ns];
  assign msg_src      = net_msg.msg_control[c_net_msg_cnbits-ns-1 -: ns];
  assign msg_mem_ctrl = net_msg.msg_control[c_mem_msg_cnbits-1:0];

  assign misrouted = (msg_dest != ns'(p_net_dest)) ||
                     (int'(msg_src) >= p_num_ports);

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic in_fire, enq, deq, drop;

  assign net_msg.rdy  = !reset && (state != FULL);
  assign mem_resp.val = (state != EMPTY);

  assign in_fire = net_msg.val && net_msg.rdy;
  // A discarded message still completes its handshake; it just never
  // reaches the queue, so it cannot disturb the head or the count.
  assign drop    = in_fire && misrouted;
  assign enq     = in_fire && !misrouted;
  assign deq     = mem_resp.val && mem_resp.rdy;

  // Outputs always come from storage: a message accepted this cycle is
  // visible only from the next cycle on.
  assign mem_resp.domain      = entries[rd_ptr].domain;
  assign mem_resp.src         = entries[rd_ptr].src;
  assign mem_resp.msg_control = entries[rd_ptr].ctrl;
  assign mem_resp.msg_data    = entries[rd_ptr].data;

  // ---------------------------------------------------------------------
  // Occupancy FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (enq) state_next = ONE;
      // enq+deq at ONE keeps one entry: the new one becomes head.
      ONE: begin
        if (enq && !deq)      state_next = FULL;
        else if (deq && !enq) state_next = EMPTY;
      end
      FULL:  if (deq) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) entries[i] <= '0;
    end else begin
      if (enq) begin
        entries[wr_ptr] <= '{domain: net_msg.domain,
                             src:    msg_src,
                             ctrl:   msg_mem_ctrl,
                             data:   net_msg.msg_data};
        wr_ptr <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
    end
  end

  // ---------------------------------------------------------------------
  // Drop accounting
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= 8'd0;
      drop_err   <= 1'b0;
    end else if (drop) begin
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_plab5_mcore_net_msg_to_mem_resp_msg.sv
module tb_plab5_mcore_net_msg_to_mem_resp_msg;

  localparam int NET_DEST  = 0;
  localparam int NUM_PORTS = 4;

  logic       clk;
  logic       reset;
  logic [7:0] drop_count;
  logic       drop_err;

  int checks   = 0;
  int failures = 0;

  plab5_net_msg_if  #(.p_cnbits(23), .p_dnbits(32))                 net_msg ();
  plab5_mem_resp_if #(.p_cnbits(13), .p_dnbits(32), .p_snbits(3))   mem_resp ();

  plab5_mcore_net_msg_to_mem_resp_msg #(
    .p_net_dest(NET_DEST), .p_num_ports(NUM_PORTS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .net_msg    (net_msg),
    .mem_resp   (mem_resp),
    .drop_count (drop_count),
    .drop_err   (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: a plain FIFO of accepted, correctly routed messages
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic        dom;
    logic [2:0]  src;
    logic [12:0] ctrl;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_drops = 0;
  bit   m_err   = 0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_drops = 0;
      m_err   = 0;
    end else begin
      logic [2:0] d, s;
      bit acc, pop;
      d   = net_msg.msg_control[22:20];
      s   = net_msg.msg_control[19:17];
      acc = net_msg.val && (mq.size() < 2);
      pop = (mq.size() != 0) && mem_resp.rdy;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        if (int'(d) != NET_DEST || int'(s) >= NUM_PORTS) begin
          if (m_drops < 255) m_drops++;
          m_err = 1;
        end else begin
          mq.push_back('{dom: net_msg.domain, src: s,
                         ctrl: net_msg.msg_control[12:0], data: net_msg.msg_data});
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("in_rdy",     64'(net_msg.rdy),  64'(!reset && mq.size() < 2));
    check("out_val",    64'(mem_resp.val), 64'(mq.size() != 0));
    check("drop_count", 64'(drop_count),   64'(m_drops));
    check("drop_err",   64'(drop_err),     64'(m_err));
    if (mq.size() != 0) begin
      check("out_ctrl",   64'(mem_resp.msg_control), 64'(mq[0].ctrl));
      check("out_data",   64'(mem_resp.msg_data),    64'(mq[0].data));
      check("out_src",    64'(mem_resp.src),         64'(mq[0].src));
      check("out_domain", 64'(mem_resp.domain),      64'(mq[0].dom));
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Net opaque is set to a non-zero pattern to show it is ignored.
  task automatic drive(input logic v, input logic [2:0] d, input logic [2:0] s,
                       input logic [12:0] c, input logic [31:0] dat, input logic dom);
    net_msg.val         = v;
    net_msg.msg_control = {d, s, 4'hA, c};
    net_msg.msg_data    = dat;
    net_msg.domain      = dom;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 3'd0, 13'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    mem_resp.rdy = 1'b0;
    idle();

    // 1: reset and idle
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("t1_in_rdy",   64'(net_msg.rdy),          64'd1);
    check("t1_out_val",  64'(mem_resp.val),         64'd0);
    check("t1_drops",    64'(drop_count),           64'd0);
    check("t1_ctrl",     64'(mem_resp.msg_control), 64'd0);
    check("t1_data",     64'(mem_resp.msg_data),    64'd0);
    check("t1_src",      64'(mem_resp.src),         64'd0);
    check("t1_domain",   64'(mem_resp.domain),      64'd0);

    // 2: single pass-through
    mem_resp.rdy = 1'b1;
    drive(1'b1, 3'd0, 3'd2, 13'h0A55, 32'hDEADBEEF, 1'b1);
    tick();
    idle();
    check("t2_out_val",  64'(mem_resp.val),         64'd1);
    check("t2_ctrl",     64'(mem_resp.msg_control), 64'h0A55);
    check("t2_data",     64'(mem_resp.msg_data),    64'hDEADBEEF);
    check("t2_src",      64'(mem_resp.src),         64'd2);
    check("t2_domain",   64'(mem_resp.domain),      64'd1);
    tick();
    check("t2_drained",  64'(mem_resp.val),         64'd0);

    // 3: back-pressure, A B C
    mem_resp.rdy = 1'b0;
    drive(1'b1, 3'd0, 3'd1, 13'h0111, 32'hAAAA0001, 1'b0);
    tick();
    drive(1'b1, 3'd0, 3'd3, 13'h0222, 32'hBBBB0002, 1'b1);
    tick();
    drive(1'b1, 3'd0, 3'd0, 13'h0333, 32'hCCCC0003, 1'b0);
    #1;
    check("t3_full_rdy", 64'(net_msg.rdy),          64'd0);
    tick();
    check("t3_head_a",   64'(mem_resp.msg_data),    64'hAAAA0001);
    mem_resp.rdy = 1'b1;
    tick();
    check("t3_head_b",   64'(mem_resp.msg_data),    64'hBBBB0002);
    check("t3_dom_b",    64'(mem_resp.domain),      64'd1);
    tick();
    idle();
    check("t3_head_c",   64'(mem_resp.msg_data),    64'hCCCC0003);
    check("t3_ctrl_c",   64'(mem_resp.msg_control), 64'h0333);
    tick();
    check("t3_empty",    64'(mem_resp.val),         64'd0);

    // 4: streaming at count=1, pointers wrap repeatedly
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'd0, 3'(i % 4), 13'(16'h0100 + i), 32'h1000 + 32'(i), 1'(i));
      tick();
      check("t4_head",   64'(mem_resp.msg_data),    64'h1000 + 64'(i));
      check("t4_rdy",    64'(net_msg.rdy),          64'd1);
    end
    idle();
    tick();
    check("t4_empty",    64'(mem_resp.val),         64'd0);

    // 5: misrouted messages
    mem_resp.rdy = 1'b0;
    drive(1'b1, 3'd3, 3'd1, 13'h1FFF, 32'h0BAD0001, 1'b1);
    tick();
    drive(1'b1, 3'd0, 3'd4, 13'h1FFF, 32'h0BAD0002, 1'b1);
    tick();
    idle();
    check("t5_out_val",  64'(mem_resp.val),         64'd0);
    check("t5_drops",    64'(drop_count),           64'd2);
    check("t5_err",      64'(drop_err),             64'd1);
    // drop coinciding with a dequeue acts as a plain dequeue
    drive(1'b1, 3'd0, 3'd1, 13'h0042, 32'h60060001, 1'b0);
    tick();
    mem_resp.rdy = 1'b1;
    drive(1'b1, 3'd5, 3'd1, 13'h0043, 32'h0BAD0003, 1'b1);
    tick();
    idle();
    check("t5_drop_deq", 64'(mem_resp.val),         64'd0);
    check("t5_drops3",   64'(drop_count),           64'd3);
    for (int i = 0; i < 297; i++) begin
      drive(1'b1, 3'(1 + i % 7), 3'd0, 13'h0, 32'(i), 1'b0);
      tick();
    end
    idle();
    check("t5_saturate", 64'(drop_count),           64'd255);

    // 6: reset while FULL
    mem_resp.rdy = 1'b0;
    drive(1'b1, 3'd0, 3'd1, 13'h0777, 32'h57A1E001, 1'b1);
    tick();
    drive(1'b1, 3'd0, 3'd2, 13'h0778, 32'h57A1E002, 1'b1);
    tick();
    idle();
    check("t6_full",     64'(net_msg.rdy),          64'd0);
    reset = 1'b1;
    #1;
    check("t6_rst_rdy",  64'(net_msg.rdy),          64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("t6_out_val",  64'(mem_resp.val),         64'd0);
    check("t6_in_rdy",   64'(net_msg.rdy),          64'd1);
    check("t6_drops",    64'(drop_count),           64'd0);
    check("t6_err",      64'(drop_err),             64'd0);
    mem_resp.rdy = 1'b1;
    repeat (3) tick();
    check("t6_no_stale", 64'(mem_resp.val),         64'd0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
